// File: rtl/bitbrick_seq_ctrl.sv
// Sequencer that runs a full 2/4/8-bit signed/unsigned multiply through one 2-bit bitbrick,
// issuing every slice pair and shift-accumulating the returned partial products.
module bitbrick_seq_ctrl #(
    parameter int MAX_BITS = 8,
    parameter int BB_LAT   = 1,
    parameter int ACC_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] a,
    input  logic [MAX_BITS-1:0] b,
    input  logic                sign_a,
    input  logic                sign_b,
    input  logic [1:0]          prec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_result,
    output logic [1:0]          bb_x,
    output logic [1:0]          bb_y,
    output logic                bb_sign_x,
    output logic                bb_sign_y,
    input  logic [5:0]          bb_p
);

    localparam int SLICES = MAX_BITS / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int SH_W   = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [MAX_BITS-1:0] a_q, b_q;
    logic                sa_q, sb_q;
    logic [IDX_W-1:0]    last_q, last_sel;
    logic [IDX_W-1:0]    i_q, j_q;
    logic [IDX_W:0]      ij_sum;
    logic                accept, issue_last, drain_done;
    logic [BB_LAT:0]     tag_v;
    logic [SH_W-1:0]     tag_sh [BB_LAT+1];
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    pp_ext;

    always_comb begin
        last_sel = IDX_W'(SLICES - 1);
        case (prec)
            2'b00:   last_sel = '0;
            2'b01:   last_sel = IDX_W'(1);
            default: last_sel = IDX_W'(SLICES - 1);
        endcase
    end

    assign accept     = in_valid && (state == IDLE);
    assign issue_last = (state == RUN) && (i_q == last_q) && (j_q == last_q);
    // Stage 0 lines up with the registered bb_* outputs; stage BB_LAT lines up with bb_p.
    assign drain_done = tag_v[BB_LAT] && (tag_v[BB_LAT-1:0] == '0);
    assign ij_sum     = {1'b0, i_q} + {1'b0, j_q};
    assign pp_ext     = {{(ACC_W-6){bb_p[5]}}, bb_p};
    assign out_result = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            last_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            bb_x      <= '0;
            bb_y      <= '0;
            bb_sign_x <= 1'b0;
            bb_sign_y <= 1'b0;
            tag_v     <= '0;
            for (int unsigned k = 0; k <= BB_LAT; k++) tag_sh[k] <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                sa_q   <= sign_a;
                sb_q   <= sign_b;
                last_q <= last_sel;
                i_q    <= '0;
                j_q    <= '0;
            end else if (state == RUN) begin
                if (j_q == last_q) begin
                    j_q <= '0;
                    if (i_q != last_q) i_q <= i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end

            if (state == RUN) begin
                bb_x      <= a_q[{i_q, 1'b0} +: 2];
                bb_y      <= b_q[{j_q, 1'b0} +: 2];
                bb_sign_x <= sa_q && (i_q == last_q);
                bb_sign_y <= sb_q && (j_q == last_q);
            end else begin
                bb_x      <= '0;
                bb_y      <= '0;
                bb_sign_x <= 1'b0;
                bb_sign_y <= 1'b0;
            end

            tag_v[0]  <= (state == RUN);
            tag_sh[0] <= {ij_sum, 1'b0};
            for (int unsigned k = 1; k <= BB_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_sh[k] <= tag_sh[k-1];
            end

            if (accept)             acc <= '0;
            else if (tag_v[BB_LAT]) acc <= acc + (pp_ext << tag_sh[BB_LAT]);
        end
    end

endmodule

// File: tb/tb_bitbrick_seq_ctrl.sv
// Bench for bitbrick_seq_ctrl: a registered bitbrick model, a table of known products,
// randomized ops against an arithmetic reference, plus backpressure and mid-op reset sequences.
module tb_bitbrick_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b;
    logic        sign_a, sign_b;
    logic [1:0]  prec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  bb_x, bb_y;
    logic        bb_sign_x, bb_sign_y;
    logic [5:0]  bb_p = 6'd0;

    int passed = 0;
    int total  = 0;
    int sx_cnt, sy_cnt;

    bitbrick_seq_ctrl #(.MAX_BITS(8), .BB_LAT(1), .ACC_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sign_a(sign_a), .sign_b(sign_b), .prec(prec),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .bb_x(bb_x), .bb_y(bb_y), .bb_sign_x(bb_sign_x), .bb_sign_y(bb_sign_y),
        .bb_p(bb_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] bb_mul(input logic [1:0] x, input logic [1:0] y,
                                          input logic sx, input logic sy);
        int xv, yv;
        xv = int'(x);
        yv = int'(y);
        if (sx && x[1]) xv = xv - 4;
        if (sy && y[1]) yv = yv - 4;
        return 6'(xv * yv);
    endfunction

    // Bitbrick with one cycle of latency
    always @(posedge clk) bb_p <= bb_mul(bb_x, bb_y, bb_sign_x, bb_sign_y);

    function automatic int n_of(input logic [1:0] pr);
        return (pr == 2'b00) ? 1 : (pr == 2'b01) ? 2 : 4;
    endfunction

    function automatic int ref_mul(input logic [7:0] av, input logic [7:0] bv,
                                   input logic sa, input logic sb, input logic [1:0] pr);
        int w, x, y;
        w = 2 * n_of(pr);
        x = int'(av) & ((1 << w) - 1);
        y = int'(bv) & ((1 << w) - 1);
        if (sa && x >= (1 << (w - 1))) x = x - (1 << w);
        if (sb && y >= (1 << (w - 1))) y = y - (1 << w);
        return (x * y) & 32'hFFFF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic launch(input logic [7:0] la, input logic [7:0] lb,
                          input logic lsa, input logic lsb, input logic [1:0] lpr);
        @(negedge clk);
        a = la; b = lb; sign_a = lsa; sign_b = lsb; prec = lpr;
        in_valid = 1'b1;
        check("rdy_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        sign_a = 1'($urandom); sign_b = 1'($urandom); prec = 2'($urandom);
    endtask

    task automatic collect(input string tag, input logic [7:0] la, input logic [7:0] lb,
                           input logic lsa, input logic lsb, input logic [1:0] lpr,
                           input int exp_res);
        int n, lat, ok_seq, ii, jj, ex, ac;
        n = n_of(lpr);
        lat = -1;
        ok_seq = 1;
        sx_cnt = 0;
        sy_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            ac = (int'(bb_x) << 4) | (int'(bb_y) << 2) | (int'(bb_sign_x) << 1) | int'(bb_sign_y);
            if (k <= n * n) begin
                ii = (k - 1) / n;
                jj = (k - 1) % n;
                ex = (((int'(la) >> (2 * ii)) & 3) << 4) | (((int'(lb) >> (2 * jj)) & 3) << 2)
                   | (int'(lsa && ii == n - 1) << 1) | int'(lsb && jj == n - 1);
                if (ac != ex) ok_seq = 0;
                sx_cnt += int'(bb_sign_x);
                sy_cnt += int'(bb_sign_y);
            end else if (ac != 0) begin
                ok_seq = 0;
            end
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, n * n + 2);
        check({tag, "_res"}, int'(out_result), exp_res);
        check({tag, "_issue"}, ok_seq, 1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, int'(out_valid), 0);
        check({tag, "_rdy_back"}, int'(in_ready), 1);
    endtask

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vsa;
        logic        vsb;
        logic [1:0]  vpr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] ra, rb;
        logic       rsa, rsb;
        logic [1:0] rpr;
        int         held;

        vecs[0] = '{8'hB6, 8'h5F, 1'b1, 1'b0, 2'b00, 16'hFFFA};
        vecs[1] = '{8'h0F, 8'h0F, 1'b0, 1'b0, 2'b01, 16'h00E1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 1'b1, 2'b10, 16'hC080};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 2'b10, 16'h0001};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 16'hFE01};
        vecs[5] = '{8'hFE, 8'hFF, 1'b1, 1'b0, 2'b10, 16'hFE02};
        vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b1, 2'b11, 16'hC080};
        vecs[7] = '{8'h38, 8'h07, 1'b1, 1'b1, 2'b01, 16'hFFC8};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sign_a = 1'b0; sign_b = 1'b0; prec = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_result", int'(out_result), 0);
        check("rst_bb", int'({bb_x, bb_y, bb_sign_x, bb_sign_y}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].va, vecs[v].vb, vecs[v].vsa, vecs[v].vsb, vecs[v].vpr);
            collect($sformatf("vec%0d", v), vecs[v].va, vecs[v].vb, vecs[v].vsa, vecs[v].vsb,
                    vecs[v].vpr, int'(vecs[v].exp));
            if (v == 5) begin
                check("vec5_sign_x_cnt", sx_cnt, 4);
                check("vec5_sign_y_cnt", sy_cnt, 0);
            end
            handshake($sformatf("vec%0d", v));
        end

        // Backpressure with a new request pending
        launch(8'h0A, 8'h06, 1'b0, 1'b0, 2'b01);
        collect("bp", 8'h0A, 8'h06, 1'b0, 1'b0, 2'b01, 16'h003C);
        a = 8'h03; b = 8'h05; sign_a = 1'b0; sign_b = 1'b0; prec = 2'b01;
        in_valid = 1'b1;
        held = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (out_result != 16'h003C || in_ready || !out_valid) held = 0;
        end
        check("bp_held", held, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_ov_drop", int'(out_valid), 0);
        check("bp_rdy_rise", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'hFF; b = 8'hFF; prec = 2'b10;
        check("bp_accepted", int'(in_ready), 0);
        collect("bp2", 8'h03, 8'h05, 1'b0, 1'b0, 2'b01, 16'h000F);
        handshake("bp2");

        // Reset after five issues of an 8-bit op
        launch(8'h5A, 8'hC3, 1'b1, 1'b1, 2'b10);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_in_ready", int'(in_ready), 1);
        check("mr_bb", int'({bb_x, bb_y, bb_sign_x, bb_sign_y}), 0);
        check("mr_result", int'(out_result), 0);
        @(negedge clk);
        reset = 1'b0;
        launch(8'h03, 8'h05, 1'b0, 1'b0, 2'b01);
        collect("mr_next", 8'h03, 8'h05, 1'b0, 1'b0, 2'b01, 16'h000F);
        handshake("mr_next");

        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rsa = 1'($urandom); rsb = 1'($urandom);
            rpr = 2'($urandom_range(0, 3));
            launch(ra, rb, rsa, rsb, rpr);
            collect($sformatf("rnd%0d", r), ra, rb, rsa, rsb, rpr, ref_mul(ra, rb, rsa, rsb, rpr));
            handshake($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
